// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: two requesters share one LED through a round-robin
// valid/ready arbiter; a phase-counter FSM plays OFF/ON/BLINK/BURST patterns.
module led_pattern_sched #(
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [1:0]          req0_mode,
  input  logic [PERIOD_W-1:0] req0_half_period,
  input  logic [CNT_W-1:0]    req0_count,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [1:0]          req1_mode,
  input  logic [PERIOD_W-1:0] req1_half_period,
  input  logic [CNT_W-1:0]    req1_count,
  output logic                led_out,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK_HI,
    S_BLINK_LO,
    S_BURST_HI,
    S_BURST_LO
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  state_t              state_q, state_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic                prio1_q, prio1_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0]    pulses_q, pulses_d;
  logic [1:0]          saved_mode_q, saved_mode_d;
  logic [PERIOD_W-1:0] saved_hp_q, saved_hp_d;

  logic                window_open, grant0, grant1, accept, real_cmd, phase_zero;
  logic [1:0]          cmd_mode, cur_mode;
  logic [PERIOD_W-1:0] cmd_hp;
  logic [CNT_W-1:0]    cmd_count;

  // A half-period of 0 behaves like 1, so the counter reload saturates at 0.
  function automatic logic [PERIOD_W-1:0] phase_load(input logic [PERIOD_W-1:0] hp);
    return (hp == '0) ? '0 : hp - PERIOD_W'(1);
  endfunction

  assign window_open = reset_n && (state_q != S_BURST_HI) && (state_q != S_BURST_LO);
  assign grant1      = req1_valid && (!req0_valid || prio1_q);
  assign grant0      = req0_valid && !grant1;
  assign req0_ready  = window_open && grant0;
  assign req1_ready  = window_open && grant1;
  assign accept      = req0_ready || req1_ready;
  assign cmd_mode    = grant1 ? req1_mode        : req0_mode;
  assign cmd_hp      = grant1 ? req1_half_period : req0_half_period;
  assign cmd_count   = grant1 ? req1_count       : req0_count;
  // A zero-count burst is a handshake only; the running pattern keeps going.
  assign real_cmd    = accept && !((cmd_mode == MODE_BURST) && (cmd_count == '0));
  assign phase_zero  = (phase_q == '0);

  always_comb begin
    cur_mode = MODE_OFF;
    case (state_q)
      S_ON:                   cur_mode = MODE_ON;
      S_BLINK_HI, S_BLINK_LO: cur_mode = MODE_BLINK;
      default:                cur_mode = MODE_OFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    prio1_d      = prio1_q;
    phase_d      = phase_q;
    hp_d         = hp_q;
    pulses_d     = pulses_q;
    saved_mode_d = saved_mode_q;
    saved_hp_d   = saved_hp_q;

    if (accept) begin
      grant_d = grant1;
      prio1_d = !grant1;
    end

    if (real_cmd) begin
      case (cmd_mode)
        MODE_OFF: begin
          state_d = S_OFF;
          led_d   = 1'b0;
        end
        MODE_ON: begin
          state_d = S_ON;
          led_d   = 1'b1;
        end
        MODE_BLINK: begin
          state_d = S_BLINK_HI;
          led_d   = 1'b1;
          hp_d    = cmd_hp;
          phase_d = phase_load(cmd_hp);
        end
        default: begin
          saved_mode_d = cur_mode;
          saved_hp_d   = hp_q;
          state_d      = S_BURST_HI;
          led_d        = 1'b1;
          busy_d       = 1'b1;
          hp_d         = cmd_hp;
          phase_d      = phase_load(cmd_hp);
          pulses_d     = cmd_count;
        end
      endcase
    end else begin
      case (state_q)
        S_BLINK_HI, S_BLINK_LO, S_BURST_HI: begin
          if (phase_zero) begin
            phase_d = phase_load(hp_q);
            led_d   = (state_q == S_BLINK_LO);
            case (state_q)
              S_BLINK_HI: state_d = S_BLINK_LO;
              S_BLINK_LO: state_d = S_BLINK_HI;
              default:    state_d = S_BURST_LO;
            endcase
          end else begin
            phase_d = phase_q - PERIOD_W'(1);
          end
        end
        S_BURST_LO: begin
          if (!phase_zero) begin
            phase_d = phase_q - PERIOD_W'(1);
          end else if (pulses_q == CNT_W'(1)) begin
            // Last low phase done: drop busy and resume the saved pattern.
            busy_d = 1'b0;
            case (saved_mode_q)
              MODE_ON: begin
                state_d = S_ON;
                led_d   = 1'b1;
              end
              MODE_BLINK: begin
                state_d = S_BLINK_HI;
                led_d   = 1'b1;
                hp_d    = saved_hp_q;
                phase_d = phase_load(saved_hp_q);
              end
              default: begin
                state_d = S_OFF;
                led_d   = 1'b0;
              end
            endcase
          end else begin
            pulses_d = pulses_q - CNT_W'(1);
            state_d  = S_BURST_HI;
            led_d    = 1'b1;
            phase_d  = phase_load(hp_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_OFF;
      led_q        <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      prio1_q      <= 1'b0;
      phase_q      <= '0;
      hp_q         <= '0;
      pulses_q     <= '0;
      saved_mode_q <= MODE_OFF;
      saved_hp_q   <= '0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      prio1_q      <= prio1_d;
      phase_q      <= phase_d;
      hp_q         <= hp_d;
      pulses_q     <= pulses_d;
      saved_mode_q <= saved_mode_d;
      saved_hp_q   <= saved_hp_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a timeline model.
module tb_led_pattern_sched;

  localparam int PW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]    req0_mode, req1_mode;
  logic [PW-1:0] req0_half_period, req1_half_period;
  logic [CW-1:0] req0_count, req1_count;
  logic          led_out, busy, grant_id;

  int errors = 0;
  int checks = 0;

  led_pattern_sched #(.PERIOD_W(PW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_mode        (req0_mode),
    .req0_half_period (req0_half_period),
    .req0_count       (req0_count),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_mode        (req1_mode),
    .req1_half_period (req1_half_period),
    .req1_count       (req1_count),
    .led_out          (led_out),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  // Model: the active pattern plus the number of cycles since it started;
  // the LED level is derived from that elapsed time by division.
  int m_mode = 0, m_hp = 1, m_t = 0, m_cnt = 0, m_saved_mode = 0, m_saved_hp = 1;
  bit m_last = 1'b1, m_gid = 1'b0;
  bit s_g;
  int s_md, s_hp, s_c;

  function automatic int eff(input int hp);
    return (hp == 0) ? 1 : hp;
  endfunction

  function automatic bit model_led();
    if (m_mode == 0) return 1'b0;
    if (m_mode == 1) return 1'b1;
    return ((m_t / eff(m_hp)) % 2) == 0;
  endfunction

  function automatic bit model_open();
    return reset_n && (m_mode != 3);
  endfunction

  function automatic bit model_g1();
    return req1_valid && (!req0_valid || !m_last);
  endfunction

  function automatic bit model_g0();
    return req0_valid && !model_g1();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_hp <= 1; m_t <= 0; m_cnt <= 0;
      m_saved_mode <= 0; m_saved_hp <= 1; m_last <= 1'b1; m_gid <= 1'b0;
    end else if (model_open() && (req0_valid || req1_valid)) begin
      s_g  = model_g1();
      s_md = s_g ? int'(req1_mode) : int'(req0_mode);
      s_hp = s_g ? int'(req1_half_period) : int'(req0_half_period);
      s_c  = s_g ? int'(req1_count) : int'(req0_count);
      m_last <= s_g;
      m_gid  <= s_g;
      if (s_md == 3 && s_c == 0) begin
        m_t <= m_t + 1;
      end else if (s_md == 3) begin
        m_saved_mode <= m_mode; m_saved_hp <= m_hp;
        m_mode <= 3; m_hp <= s_hp; m_cnt <= s_c; m_t <= 0;
      end else begin
        m_mode <= s_md;
        if (s_md == 2) m_hp <= s_hp;
        m_t <= 0;
      end
    end else if (m_mode == 3 && m_t + 1 == 2 * eff(m_hp) * m_cnt) begin
      m_mode <= m_saved_mode; m_hp <= m_saved_hp; m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    checkOutput("model_led", led_out, model_led());
    checkOutput("model_busy", busy, m_mode == 3);
    checkOutput("model_grant_id", grant_id, m_gid);
    checkOutput("model_ready0", req0_ready, model_open() && model_g0());
    checkOutput("model_ready1", req1_ready, model_open() && model_g1());
  end

  task automatic applyStimulus(input bit v0, input int md0, input int hp0, input int c0,
                               input bit v1, input int md1, input int hp1, input int c1);
    req0_valid = v0; req0_mode = 2'(md0); req0_half_period = PW'(hp0); req0_count = CW'(c0);
    req1_valid = v1; req1_mode = 2'(md1); req1_half_period = PW'(hp1); req1_count = CW'(c1);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  bit p1 [6]  = '{1, 1, 1, 0, 0, 0};
  bit p4 [14] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    int busyc, rises;
    bit prev;
    $display("[TB] start");
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_led", led_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", grant_id, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // Blink with 3-cycle phases
    @(negedge clk);
    applyStimulus(1, 2, 3, 0, 0, 0, 0, 0);
    #3 checkOutput("t1_ready0", req0_ready, 1);
    @(negedge clk);
    idle();
    for (int i = 0; i < 6; i++) begin
      #3;
      checkOutput("t1_led", led_out, p1[i]);
      checkOutput("t1_grant", grant_id, 0);
      @(negedge clk);
    end

    // Tie after reset: req0 first, then req1
    doReset();
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
    #3;
    checkOutput("t2_ready0", req0_ready, 1);
    checkOutput("t2_ready1", req1_ready, 0);
    @(negedge clk);
    #3;
    checkOutput("t2_led_on", led_out, 1);
    checkOutput("t2_grant0", grant_id, 0);
    checkOutput("t2_tie_ready1", req1_ready, 1);
    @(negedge clk);
    idle();
    #3;
    checkOutput("t2_led_off", led_out, 0);
    checkOutput("t2_grant1", grant_id, 1);

    // Burst over ON, req0 probing the closed window
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 1, 3, 2, 3);
    #3 checkOutput("t3_ready1", req1_ready, 1);
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      #3;
      checkOutput("t3_busy", busy, 1);
      checkOutput("t3_led", led_out, (i % 4) < 2);
      checkOutput("t3_ready0_closed", req0_ready, 0);
      @(negedge clk);
    end
    #3;
    checkOutput("t3_busy_done", busy, 0);
    checkOutput("t3_led_restored", led_out, 1);
    checkOutput("t3_reopen", req0_ready, 1);

    // Burst interrupting a 5-cycle blink
    @(negedge clk);
    applyStimulus(1, 2, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 3, 1, 2);
    #3 checkOutput("t4_ready1", req1_ready, 1);
    @(negedge clk);
    idle();
    for (int i = 0; i < 14; i++) begin
      #3 checkOutput("t4_led", led_out, p4[i]);
      @(negedge clk);
    end

    // hp=0 blink, then a zero-count burst that must not disturb it
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) begin
      #3 checkOutput("t5_hp0_led", led_out, (i % 2) == 0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 1, 3, 7, 0);
    @(negedge clk);
    idle();
    #3;
    checkOutput("t5_noop_busy", busy, 0);
    checkOutput("t5_noop_grant", grant_id, 1);
    checkOutput("t5_noop_led", led_out, 0);

    // Maximum-count burst from OFF
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 3, 0, 15);
    @(negedge clk);
    idle();
    busyc = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #3;
      if (busy) busyc++;
      if (led_out && !prev) rises++;
      prev = led_out;
      @(negedge clk);
    end
    checkOutput("t5_pulses", rises, 15);
    checkOutput("t5_busy_cycles", busyc, 30);
    checkOutput("t5_led_off", led_out, 0);

    // Reset during the second pulse of a burst
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 3, 4, 3);
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    #2;
    checkOutput("t6_busy_before", busy, 1);
    checkOutput("t6_led_before", led_out, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_led_async", led_out, 0);
    checkOutput("t6_busy_async", busy, 0);
    checkOutput("t6_ready_async", req0_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
    #3;
    checkOutput("t6_tie_ready0", req0_ready, 1);
    checkOutput("t6_tie_ready1", req1_ready, 0);
    @(negedge clk);
    idle();
    #3;
    checkOutput("t6_grant", grant_id, 0);
    checkOutput("t6_led", led_out, 0);

    // Randomized traffic, checked every cycle by the model
    repeat (2000) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
Owns the single board LED and shares it between two requesters (req0, req1). Each requester issues pattern commands over a valid/ready handshake: steady OFF, steady ON, continuous BLINK, or a finite BURST of pulses. A round-robin arbiter picks which command is accepted. A phase-counter FSM drives a registered led_out. After a BURST completes, the LED returns to the persistent pattern that was active before the BURST.

Parameters:
PERIOD_W, 16, width of half-period field; phase length in clk cycles
CNT_W, 4, width of burst pulse count field

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle when high with valid
req0_mode  input  2  0=OFF 1=ON 2=BLINK 3=BURST
req0_half_period  input  PERIOD_W  cycles per high/low phase (BLINK, BURST)
req0_count  input  CNT_W  pulses for BURST
req1_valid, req1_ready, req1_mode, req1_half_period, req1_count  same as req0, for requester 1
led_out  output  1  registered LED drive
busy  output  1  high while a BURST is executing
grant_id  output  1  registered id of last accepted requester

Behaviour:
- Reset (async assert): led_out=0, busy=0, grant_id=0, state=OFF, saved mode=OFF, RR pointer favours req0. Both readies are 0 while reset_n is low.
- States: S_OFF, S_ON, S_BLINK_HI, S_BLINK_LO, S_BURST_HI, S_BURST_LO.
- Acceptance window: open in S_OFF, S_ON, S_BLINK_*. Closed in S_BURST_* (both readies 0).
- Arbitration: with the window open, readyN = validN and grantedN (combinational).
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last wins. After reset, req0 wins the first tie.
  - The RR pointer and grant_id update only on an accepted handshake.
- Latency: a command accepted at rising edge N sets led_out to its first level at edge N, visible in cycle N+1. The new state also takes effect at edge N.
- half_period of 0 is treated as 1. Each phase lasts exactly max(hp,1) cycles.
  - The phase counter loads hp-1 at phase entry, decrements each cycle, and switches phase on the cycle it reads 0.
- OFF: led_out=0. ON: led_out=1.
- BLINK: enters S_BLINK_HI (led=1), alternates HI/LO forever. Period is 2*hp.
  - A new BLINK while blinking restarts at HI with the new hp.
- BURST, count>0: saves the current persistent mode (OFF/ON/BLINK plus its hp), enters S_BURST_HI (led=1, busy=1).
  - Runs count pulses, each hp high then hp low.
  - After the final low phase: busy=0, restore the saved mode (BLINK restarts at HI), and reopen the window in that same cycle.
- BURST, count=0: accepted as a no-op. State, led_out and busy are unchanged; grant_id and RR pointer still update.
- Pulses-remaining counter is CNT_W bits; the maximum count of 2^CNT_W-1 must complete without wrap.
- Reset asserted mid-BURST or mid-BLINK: immediately OFF, saved mode cleared, busy=0.
- Mode field, hp and count are sampled only on the accepting edge. Later input changes are ignored.

Test Plan:
1. Reset, then req0 BLINK hp=3 -> led_out 1,1,1,0,0,0 repeating from the cycle after accept; req0_ready=1 for one cycle; grant_id=0.
2. Both valid at once: req0 ON, req1 OFF -> req0 accepted first (led=1); next cycle req1 accepted (led=0); grant_id sequence 0 then 1.
3. From ON, req1 BURST hp=2 count=3 -> busy=1 for 12 cycles, led 1,1,0,0 x3; both readies 0 throughout; then led=1 (ON restored), busy=0.
4. From BLINK hp=5, BURST hp=1 count=2 -> led 1,0,1,0, then BLINK restarts at HI with 5-cycle phases.
5. Edge values: hp=0 behaves as hp=1; BURST count=0 leaves led/busy unchanged; BURST count=15 yields exactly 15 pulses.
6. Assert reset_n low during the 2nd BURST pulse -> led_out=0, busy=0 asynchronously; after release, state OFF and req0 wins the first tie.
